// File: rtl/eth_tx_pktbuf_if.sv
// AXI-Stream style bundle used on both sides of the TX frame buffer.
// master drives the beat, slave drives tready.
`timescale 1ns/1ps
interface eth_tx_pktbuf_if;
   logic        tvalid;
   logic        tready;
   logic [63:0] tdata;
   logic [7:0]  tkeep;
   logic        tlast;
   logic        tuser;

   modport master (output tvalid, tdata, tkeep, tlast, tuser, input tready);
   modport slave  (input tvalid, tdata, tkeep, tlast, tuser, output tready);
endinterface

// File: rtl/eth_tx_pktbuf.sv
// Store-and-forward Ethernet TX frame buffer.
// Frames become visible to the MAC side only once their last beat is written
// error-free; errored or overflowing frames are rewound and counted as drops.
// The read side streams committed words through a two-entry prefetch queue so
// the MAC never sees a tvalid bubble inside a frame.
`timescale 1ns/1ps
module eth_tx_pktbuf #(
   parameter int ADDR_W = 9,
   parameter int CNT_W  = 32
) (
   input  logic                   eth_clk,
   input  logic                   sys_rst156,
   eth_tx_pktbuf_if.slave         s,
   eth_tx_pktbuf_if.master        eth_tx,
   output logic [CNT_W-1:0]       stat_frames_in,
   output logic [CNT_W-1:0]       stat_frames_out,
   output logic [CNT_W-1:0]       stat_drops,
   output logic [ADDR_W:0]        buf_level
);

   localparam int              DEPTH    = 1 << ADDR_W;
   localparam logic [ADDR_W:0] FULL_LVL = {1'b1, {ADDR_W{1'b0}}};

   typedef struct packed {
      logic        last;
      logic [7:0]  keep;
      logic [63:0] data;
   } word_t;

   typedef enum logic {WR_ACCEPT, WR_DROP} wr_state_t;

   word_t           mem [DEPTH];

   // wr_ptr runs ahead over the frame being received; commit_ptr marks the end
   // of the last complete frame; fetch_ptr feeds the prefetch queue; rd_ptr
   // only advances on MAC handshakes so prefetched words still occupy space.
   logic [ADDR_W:0] wr_ptr, commit_ptr, fetch_ptr, rd_ptr, pend_frames;

   wr_state_t       wr_state, wr_state_nxt;
   logic            beat, wr_full;
   logic            wr_en, wr_commit, wr_abort, drop_cnt;

   word_t           pf_q [2];
   logic [1:0]      pf_cnt;
   logic            pf_slot, pop, fetch, sent_last;
   word_t           rd_word;

   // Never back-pressure outside reset; overload is resolved by dropping.
   assign s.tready  = ~sys_rst156;
   assign beat      = s.tvalid & s.tready;
   assign buf_level = wr_ptr - rd_ptr;
   assign wr_full   = (buf_level == FULL_LVL);

   // Write FSM state register.
   always_ff @(posedge eth_clk) begin
      if (sys_rst156) wr_state <= WR_ACCEPT;
      else            wr_state <= wr_state_nxt;
   end

   // Write FSM next state and per-beat write/commit/abort decisions.
   always_comb begin
      wr_state_nxt = wr_state;
      wr_en        = 1'b0;
      wr_commit    = 1'b0;
      wr_abort     = 1'b0;
      drop_cnt     = 1'b0;
      case (wr_state)
         WR_ACCEPT: begin
            if (beat) begin
               if (wr_full || s.tuser) begin
                  wr_abort = 1'b1;
                  if (s.tlast) drop_cnt     = 1'b1;
                  else         wr_state_nxt = WR_DROP;
               end else begin
                  wr_en     = 1'b1;
                  wr_commit = s.tlast;
               end
            end
         end
         WR_DROP: begin
            if (beat && s.tlast) begin
               drop_cnt     = 1'b1;
               wr_state_nxt = WR_ACCEPT;
            end
         end
         default: wr_state_nxt = WR_ACCEPT;
      endcase
   end

   // Frame storage; contents need no reset since pointers gate every read.
   always_ff @(posedge eth_clk) begin
      if (wr_en) mem[wr_ptr[ADDR_W-1:0]] <= '{last: s.tlast, keep: s.tkeep, data: s.tdata};
   end

   // Write and commit pointers; an abort rewinds only the uncommitted part.
   always_ff @(posedge eth_clk) begin
      if (sys_rst156) begin
         wr_ptr     <= '0;
         commit_ptr <= '0;
      end else if (wr_abort) begin
         wr_ptr     <= commit_ptr;
      end else if (wr_en) begin
         wr_ptr     <= wr_ptr + 1'b1;
         if (wr_commit) commit_ptr <= wr_ptr + 1'b1;
      end
   end

   // Read side: fetch committed words into the queue whenever a slot is free
   // or being freed this cycle, which sustains one word per cycle across
   // frame boundaries.
   assign rd_word   = mem[fetch_ptr[ADDR_W-1:0]];
   assign pop       = eth_tx.tvalid & eth_tx.tready;
   assign sent_last = pop & eth_tx.tlast;
   assign fetch     = (fetch_ptr != commit_ptr) && (pend_frames != '0) &&
                      ((pf_cnt != 2'd2) || pop);
   // Queue slot that receives the fetched word: pf_cnt minus this cycle's pop.
   assign pf_slot   = pf_cnt[1] | (pf_cnt[0] & ~pop);

   assign eth_tx.tvalid = (pf_cnt != 2'd0);
   assign eth_tx.tdata  = pf_q[0].data;
   assign eth_tx.tkeep  = pf_q[0].keep;
   assign eth_tx.tlast  = pf_q[0].last;
   assign eth_tx.tuser  = 1'b0;

   // Prefetch queue; head is the output word and holds while the MAC stalls.
   always_ff @(posedge eth_clk) begin
      if (sys_rst156) begin
         pf_cnt  <= 2'd0;
         pf_q[0] <= '0;
         pf_q[1] <= '0;
      end else begin
         if (pop)   pf_q[0]       <= pf_q[1];
         if (fetch) pf_q[pf_slot] <= rd_word;
         pf_cnt <= pf_cnt + {1'b0, fetch} - {1'b0, pop};
      end
   end

   // Read-side pointers.
   always_ff @(posedge eth_clk) begin
      if (sys_rst156) begin
         fetch_ptr <= '0;
         rd_ptr    <= '0;
      end else begin
         if (fetch) fetch_ptr <= fetch_ptr + 1'b1;
         if (pop)   rd_ptr    <= rd_ptr + 1'b1;
      end
   end

   // Committed-but-unsent frame count.
   always_ff @(posedge eth_clk) begin
      if (sys_rst156) pend_frames <= '0;
      else begin
         case ({wr_en & wr_commit, sent_last})
            2'b10:   pend_frames <= pend_frames + 1'b1;
            2'b01:   pend_frames <= pend_frames - 1'b1;
            default: pend_frames <= pend_frames;
         endcase
      end
   end

   // Statistics counters, wrapping naturally.
   always_ff @(posedge eth_clk) begin
      if (sys_rst156) begin
         stat_frames_in  <= '0;
         stat_frames_out <= '0;
         stat_drops      <= '0;
      end else begin
         if (wr_en & wr_commit) stat_frames_in  <= stat_frames_in + 1'b1;
         if (sent_last)         stat_frames_out <= stat_frames_out + 1'b1;
         if (drop_cnt)          stat_drops      <= stat_drops + 1'b1;
      end
   end

endmodule

// File: tb/tb_eth_tx_pktbuf.sv
// Directed bench for eth_tx_pktbuf with a 16-word buffer.
`timescale 1ns/1ps
module tb_eth_tx_pktbuf;
   localparam int AW = 4;
   localparam int CW = 32;

   logic          eth_clk    = 1'b0;
   logic          sys_rst156 = 1'b1;
   logic [CW-1:0] st_in, st_out, st_drop;
   logic [AW:0]   lvl;

   eth_tx_pktbuf_if s_if ();
   eth_tx_pktbuf_if m_if ();

   eth_tx_pktbuf #(.ADDR_W(AW), .CNT_W(CW)) dut (
      .eth_clk         (eth_clk),
      .sys_rst156      (sys_rst156),
      .s               (s_if),
      .eth_tx          (m_if),
      .stat_frames_in  (st_in),
      .stat_frames_out (st_out),
      .stat_drops      (st_drop),
      .buf_level       (lvl)
   );

   always #3 eth_clk = ~eth_clk;

   int cyc = 0;
   always @(posedge eth_clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;

   logic [72:0] exp_q [$];
   logic [72:0] rx_q  [$];
   int          hs_q  [$];
   int          rise_q[$];
   int          gap_err  = 0;
   int          hold_err = 0;
   logic        in_frame = 1'b0, prev_vld = 1'b0, prev_rdy = 1'b0;
   logic [72:0] prev_word = '0;
   logic [72:0] cur_word;

   assign cur_word = {m_if.tlast, m_if.tkeep, m_if.tdata};

   // Output monitor, sampled mid-cycle: records handshakes, tvalid rises,
   // mid-frame tvalid drops and data changes while stalled.
   always @(negedge eth_clk) begin
      if (sys_rst156) begin
         in_frame <= 1'b0;
         prev_vld <= 1'b0;
         prev_rdy <= 1'b0;
      end else begin
         if (in_frame && !m_if.tvalid) gap_err <= gap_err + 1;
         if (prev_vld && !prev_rdy && (!m_if.tvalid || cur_word != prev_word))
            hold_err <= hold_err + 1;
         if (m_if.tvalid && !prev_vld) rise_q.push_back(cyc);
         if (m_if.tvalid && m_if.tready) begin
            rx_q.push_back(cur_word);
            hs_q.push_back(cyc);
            in_frame <= !m_if.tlast;
         end
         prev_vld  <= m_if.tvalid;
         prev_rdy  <= m_if.tready;
         prev_word <= cur_word;
      end
   end

   task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge eth_clk);
         #1;
      end
   endtask

   // Drive one frame; beat i carries base+i. pass=1 queues it as expected output.
   task automatic send_frame(input int nb, input logic [63:0] base, input int err_beat,
                             input logic [7:0] lkeep, input bit pass, output int t0);
      t0 = 0;
      for (int i = 0; i < nb; i++) begin
         tick(1);
         s_if.tvalid = 1'b1;
         s_if.tdata  = base + 64'(i);
         s_if.tkeep  = (i == nb - 1) ? lkeep : 8'hFF;
         s_if.tlast  = (i == nb - 1);
         s_if.tuser  = (i == err_beat);
         if (pass) exp_q.push_back({s_if.tlast, s_if.tkeep, s_if.tdata});
         t0 = cyc;
      end
      tick(1);
      s_if.tvalid = 1'b0;
      s_if.tlast  = 1'b0;
      s_if.tuser  = 1'b0;
   endtask

   task automatic wait_rx(input int n, input int budget);
      int k = 0;
      while (rx_q.size() < n && k < budget) begin
         tick(1);
         k++;
      end
   endtask

   task automatic cmp_rx(input string tag);
      chk({tag, "_cnt"}, rx_q.size(), exp_q.size());
      while (rx_q.size() > 0 && exp_q.size() > 0)
         chk(tag, rx_q.pop_front(), exp_q.pop_front());
      rx_q.delete();
      exp_q.delete();
   endtask

   task automatic do_reset();
      tick(1);
      sys_rst156  = 1'b1;
      s_if.tvalid = 1'b0;
      tick(2);
      sys_rst156 = 1'b0;
      rx_q.delete();
      exp_q.delete();
      hs_q.delete();
      rise_q.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      int span;
      s_if.tvalid = 1'b0;
      s_if.tdata  = '0;
      s_if.tkeep  = '0;
      s_if.tlast  = 1'b0;
      s_if.tuser  = 1'b0;
      m_if.tready = 1'b0;
      tick(3);

      // Reset state
      chk("rst_s_tready", s_if.tready, 0);
      chk("rst_tvalid",   m_if.tvalid, 0);
      chk("rst_out_word", cur_word, 0);
      chk("rst_tuser",    m_if.tuser, 0);
      chk("rst_stats",    st_in | st_out | st_drop, 0);
      chk("rst_level",    lvl, 0);
      sys_rst156 = 1'b0;
      tick(1);
      chk("s_tready_up",  s_if.tready, 1);

      // T1: single 4-beat frame, MAC ready, latency t0+2
      m_if.tready = 1'b1;
      send_frame(4, 64'h1111_1111_1111_1111, -1, 8'h0F, 1'b1, t0);
      wait_rx(4, 50);
      tick(2);
      chk("t1_rises", rise_q.size(), 1);
      if (rise_q.size() > 0) chk("t1_latency", rise_q[0] - t0, 2);
      cmp_rx("t1_beat");
      chk("t1_frames_in",  st_in, 1);
      chk("t1_frames_out", st_out, 1);
      chk("t1_level",      lvl, 0);

      // T2: 10-beat frame, MAC stalls then toggles every cycle
      rise_q.delete();
      m_if.tready = 1'b0;
      send_frame(10, 64'hA000_0000_0000_0000, -1, 8'h3F, 1'b1, t0);
      tick(3);
      chk("t2_rises", rise_q.size(), 1);
      if (rise_q.size() > 0) chk("t2_no_cut_through", rise_q[0] - t0, 2);
      chk("t2_level_held", lvl, 10);
      for (int k = 0; k < 60 && rx_q.size() < 10; k++) begin
         tick(1);
         m_if.tready = ~m_if.tready;
      end
      m_if.tready = 1'b1;
      tick(2);
      chk("t2_gap",  gap_err, 0);
      chk("t2_hold", hold_err, 0);
      cmp_rx("t2_beat");
      chk("t2_frames_out", st_out, 2);

      // T3: tuser on beat 2 of 5 drops the frame; next clean frame passes
      send_frame(5, 64'hBAD0_0000_0000_0000, 1, 8'hFF, 1'b0, t0);
      tick(6);
      chk("t3_nothing_out", rx_q.size(), 0);
      chk("t3_drops",       st_drop, 1);
      chk("t3_level",       lvl, 0);
      send_frame(3, 64'hC000_0000_0000_0000, -1, 8'h01, 1'b1, t0);
      wait_rx(3, 40);
      tick(2);
      cmp_rx("t3_beat");
      chk("t3_frames_in", st_in, 3);

      // T4: overflow with MAC stalled: A (12) kept, B (8) dropped
      do_reset();
      m_if.tready = 1'b0;
      send_frame(12, 64'hD000_0000_0000_0000, -1, 8'hFF, 1'b1, t0);
      send_frame(8,  64'hE000_0000_0000_0000, -1, 8'hFF, 1'b0, t0);
      tick(3);
      chk("t4_drops",     st_drop, 1);
      chk("t4_level",     lvl, 12);
      chk("t4_frames_in", st_in, 1);
      m_if.tready = 1'b1;
      wait_rx(12, 60);
      tick(10);
      cmp_rx("t4_beat");
      chk("t4_level_end", lvl, 0);
      chk("t4_frames_out", st_out, 1);

      // T5: three 3-beat frames released together -> 9 contiguous beats
      do_reset();
      m_if.tready = 1'b0;
      send_frame(3, 64'hF100_0000_0000_0000, -1, 8'h80, 1'b1, t0);
      send_frame(3, 64'hF200_0000_0000_0000, -1, 8'h07, 1'b1, t0);
      send_frame(3, 64'hF300_0000_0000_0000, -1, 8'hFF, 1'b1, t0);
      tick(2);
      m_if.tready = 1'b1;
      wait_rx(9, 40);
      tick(3);
      chk("t5_hs_cnt", hs_q.size(), 9);
      span = (hs_q.size() >= 9) ? hs_q[8] - hs_q[0] : -1;
      chk("t5_span", span, 8);
      chk("t5_gap", gap_err, 0);
      cmp_rx("t5_beat");
      chk("t5_frames_out", st_out, 3);

      // T6: reset pulsed mid-output, then a clean frame
      do_reset();
      m_if.tready = 1'b0;
      send_frame(6, 64'h6600_0000_0000_0000, -1, 8'hFF, 1'b1, t0);
      m_if.tready = 1'b1;
      wait_rx(2, 30);
      sys_rst156 = 1'b1;
      tick(1);
      chk("t6_tvalid",   m_if.tvalid, 0);
      chk("t6_out_word", cur_word, 0);
      chk("t6_level",    lvl, 0);
      chk("t6_stats",    st_in | st_out | st_drop, 0);
      sys_rst156 = 1'b0;
      rx_q.delete();
      exp_q.delete();
      tick(1);
      send_frame(4, 64'h7700_0000_0000_0000, -1, 8'h1F, 1'b1, t0);
      wait_rx(4, 40);
      tick(5);
      cmp_rx("t6_beat");
      chk("t6_frames_in",  st_in, 1);
      chk("t6_frames_out", st_out, 1);
      chk("t6_hold", hold_err, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
